// File: rtl/paralelo_serial_pkg.sv
// paralelo_serial_pkg
// Shared constants and types for the byte-to-bit serializer.
//   IDLE_CHAR : comma byte sent as preamble and as idle filler
//   BIT_CNT_W : width of the bit-position counter (8 bits per byte)
//   state_t   : serializer sequencing state
package paralelo_serial_pkg;

  localparam logic [7:0] IDLE_CHAR = 8'hBC;
  localparam int         BIT_CNT_W = 3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/paralelo_serial_if.sv
// paralelo_serial_if
// Byte-side handshake plus serial-side outputs of the serializer.
//   data_in      : payload byte              (master -> slave)
//   valid_in     : data_in is valid          (master -> slave)
//   ready_out    : serializer accepts byte   (slave -> master)
//   data_out     : serial bit, MSB first     (slave -> master)
//   active_out   : preamble done, link live  (slave -> master)
//   err_reserved : accepted byte was a comma (slave -> master)
interface paralelo_serial_if;

  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;
  logic       active_out;
  logic       err_reserved;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  data_out,
    input  active_out,
    input  err_reserved
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output data_out,
    output active_out,
    output err_reserved
  );

endinterface

// File: rtl/paralelo_serial_hold.sv
// paralelo_serial_hold
// One-entry holding register between the byte handshake and the shifter.
// The entry is consumed at every byte boundary while enabled; a new byte may
// be pushed on that same edge, so the link sustains one byte per 8 clocks.
//   clk_32f, reset : bit clock, synchronous active-high reset
//   enable         : serializer is in RUN
//   boundary       : this edge loads the shift register
//   push_valid     : upstream byte valid
//   push_data      : upstream byte
//   push_ready     : entry can take a byte this cycle
//   full           : entry holds a byte not yet shifted out
//   hold_data      : stored byte
module paralelo_serial_hold (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       enable,
  input  logic       boundary,
  input  logic       push_valid,
  input  logic [7:0] push_data,
  output logic       push_ready,
  output logic       full,
  output logic [7:0] hold_data
);

  logic push;

  // A full entry frees up exactly at the boundary, so accept there too.
  assign push_ready = enable && (!full || boundary);
  assign push       = push_valid && push_ready;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      full      <= 1'b0;
      hold_data <= 8'h00;
    end else if (push) begin
      full      <= 1'b1;
      hold_data <= push_data;
    end else if (enable && boundary) begin
      full      <= 1'b0;
    end
  end

endmodule

// File: rtl/paralelo_serial.sv
// paralelo_serial
// Byte-to-bit serializer. After reset it sends NUM_BC_INIT comma bytes, then
// shifts out accepted payload bytes MSB first, one bit per clock, filling any
// byte slot with no pending payload with the comma.
//   clk_32f : bit clock, all logic on rising edge
//   reset   : synchronous active-high reset
//   bus     : slave side of paralelo_serial_if (handshake and serial outputs)
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | sending the comma preamble, byte input closed
// ST_RUN  | link active, payload accepted, comma inserted when idle
module paralelo_serial
  import paralelo_serial_pkg::*;
#(
  parameter int NUM_BC_INIT = 4
) (
  input  logic               clk_32f,
  input  logic               reset,
  paralelo_serial_if.slave   bus
);

  localparam logic [3:0] BC_LAST = 4'(NUM_BC_INIT - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [7:0]             shreg;
  logic [3:0]             bc_cnt;
  logic                   err_q;
  logic                   boundary;
  logic                   run_en;
  logic                   active;
  logic                   ready;
  logic                   xfer;
  logic                   hold_full;
  logic [7:0]             hold_data;
  logic [7:0]             next_byte;

  assign boundary = (bit_cnt == '0);

  paralelo_serial_hold u_hold (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .enable     (run_en),
    .boundary   (boundary),
    .push_valid (bus.valid_in),
    .push_data  (bus.data_in),
    .push_ready (ready),
    .full       (hold_full),
    .hold_data  (hold_data)
  );

  assign xfer      = bus.valid_in && ready;
  assign next_byte = (run_en && hold_full) ? hold_data : IDLE_CHAR;

  // FSM: state register
  always_ff @(posedge clk_32f) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  // FSM: next state; leave INIT on the boundary that loads the last comma
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (boundary && (bc_cnt == BC_LAST)) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    run_en = 1'b0;
    active = 1'b0;
    if (state == ST_RUN) begin
      run_en = 1'b1;
      active = 1'b1;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      bit_cnt <= '0;
      shreg   <= 8'h00;
      bc_cnt  <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      if (boundary) shreg <= next_byte;
      else          shreg <= {shreg[6:0], 1'b0};
      if ((state == ST_INIT) && boundary) bc_cnt <= bc_cnt + 4'd1;
      // The comma is still transmitted; the flag only reports the misuse.
      err_q <= xfer && (bus.data_in == IDLE_CHAR);
    end
  end

  assign bus.ready_out    = ready;
  assign bus.data_out     = shreg[7];
  assign bus.active_out   = active;
  assign bus.err_reserved = err_q;

endmodule

// File: tb/tb_paralelo_serial.sv
// tb_paralelo_serial
// Random and directed stimulus for paralelo_serial, checked every cycle
// against a byte-slot/queue model, plus literal checks on the captured stream.
module tb_paralelo_serial;

  localparam int         NUM_BC = 4;
  localparam logic [7:0] BC     = 8'hBC;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;

  paralelo_serial_if bus();

  paralelo_serial #(.NUM_BC_INIT(NUM_BC)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_32f = ~clk_32f;

  int tests = 0;
  int fails = 0;

  // model state: time since reset, preamble progress, pending bytes, byte on wire
  int         m_t      = 0;
  int         m_commas = 0;
  bit         m_run    = 1'b0;
  logic [7:0] m_pend[$];
  logic [7:0] m_cur    = 8'h00;
  bit         m_cur_ok = 1'b0;
  logic       exp_data, exp_ready, exp_active, exp_err;

  // stream capture from the DUT
  int         e_cnt       = 0;
  logic [7:0] rx_sr       = 8'h00;
  logic [7:0] rx_q[$];
  int         active_rise = 0;
  int         err_pulses  = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t actual=%b required=%b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic int find_byte(input int from, input logic [7:0] b);
    for (int i = from; i < rx_q.size(); i++)
      if (rx_q[i] == b) return i;
    return -1;
  endfunction

  function automatic logic [7:0] rx_at(input int idx);
    if (idx >= 0 && idx < rx_q.size()) return rx_q[idx];
    return 8'hxx;
  endfunction

  // model step on each edge, then compare DUT against it
  always @(posedge clk_32f) begin
    bit rst_e;
    bit rdy;
    bit xfer;
    rst_e = reset;
    if (rst_e) begin
      m_t      = 0;
      m_commas = 0;
      m_run    = 1'b0;
      m_pend.delete();
      m_cur_ok = 1'b0;
      exp_err  = 1'b0;
    end else begin
      rdy  = m_run && (m_pend.size() == 0 || (m_t % 8) == 0);
      xfer = bus.valid_in && rdy;
      if ((m_t % 8) == 0) begin
        if (m_commas < NUM_BC) begin
          m_cur = BC;
          m_commas++;
          if (m_commas == NUM_BC) m_run = 1'b1;
        end else if (m_pend.size() > 0) begin
          m_cur = m_pend.pop_front();
        end else begin
          m_cur = BC;
        end
        m_cur_ok = 1'b1;
      end
      if (xfer) m_pend.push_back(bus.data_in);
      exp_err = xfer && (bus.data_in == BC);
      m_t++;
    end
    #1;
    exp_active = m_run;
    exp_ready  = m_run && (m_pend.size() == 0 || (m_t % 8) == 0);
    exp_data   = m_cur_ok ? m_cur[7 - ((m_t - 1) % 8)] : 1'b0;
    chk("data_out",     bus.data_out,     exp_data);
    chk("ready_out",    bus.ready_out,    exp_ready);
    chk("active_out",   bus.active_out,   exp_active);
    chk("err_reserved", bus.err_reserved, exp_err);
    if (rst_e) begin
      e_cnt       = 0;
      active_rise = 0;
    end else begin
      e_cnt++;
      rx_sr = {rx_sr[6:0], bus.data_out};
      if ((e_cnt % 8) == 0) rx_q.push_back(rx_sr);
      if (bus.active_out && active_rise == 0) active_rise = e_cnt;
      if (bus.err_reserved) err_pulses++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_32f);
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    tick(n);
  endtask

  task automatic align(input int k);
    for (int i = 0; i < 16; i++) begin
      if ((e_cnt % 8) == k) return;
      @(negedge clk_32f);
    end
    tests++;
    fails++;
    $display("FAIL align_timeout actual=%0d required=%0d", e_cnt % 8, k);
  endtask

  // Offer a byte and hold it until the edge that accepts it.
  task automatic send(input logic [7:0] b, output int waits, output bit on_bnd);
    bit acc;
    waits  = 0;
    on_bnd = 1'b0;
    bus.valid_in = 1'b1;
    bus.data_in  = b;
    for (int i = 0; i < 64; i++) begin
      acc    = bus.ready_out;
      on_bnd = ((e_cnt % 8) == 0);
      @(negedge clk_32f);
      if (acc) return;
      waits++;
    end
    tests++;
    fails++;
    $display("FAIL send_timeout byte=%h actual=not_accepted required=accepted", b);
    bus.valid_in = 1'b0;
  endtask

  initial begin
    int         w;
    bit         bd;
    int         base;
    int         idx;
    int         e0;
    int         hits;
    logic [7:0] b;

    bus.valid_in = 1'b0;
    bus.data_in  = 8'h00;
    reset        = 1'b1;
    tick(3);
    reset = 1'b0;

    // preamble and idle commas
    tick(64);
    chk_int("rx_count_after_64", rx_q.size(), 8);
    for (int i = 0; i < 8; i++) chk8("preamble_idle_byte", rx_at(i), BC);
    chk_int("active_rise_edge", active_rise, 25);

    // single byte offered mid-byte
    tick(3);
    base = rx_q.size();
    send(8'h5A, w, bd);
    chk_int("single_accept_wait", w, 0);
    idle(24);
    idx = find_byte(base, 8'h5A);
    chk8("single_byte", rx_at(idx), 8'h5A);
    chk8("single_then_idle", rx_at(idx + 1), BC);

    // streaming with valid held high
    base = rx_q.size();
    send(8'h01, w, bd);
    send(8'h02, w, bd);
    chk("stream_02_on_boundary", bd, 1'b1);
    send(8'h03, w, bd);
    chk("stream_03_on_boundary", bd, 1'b1);
    send(8'h04, w, bd);
    chk("stream_04_on_boundary", bd, 1'b1);
    idle(40);
    idx = find_byte(base, 8'h01);
    chk8("stream_b0", rx_at(idx), 8'h01);
    chk8("stream_b1", rx_at(idx + 1), 8'h02);
    chk8("stream_b2", rx_at(idx + 2), 8'h03);
    chk8("stream_b3", rx_at(idx + 3), 8'h04);

    // back-to-back offer mid-byte: second waits for the boundary
    align(3);
    base = rx_q.size();
    send(8'h33, w, bd);
    chk_int("b2b_first_wait", w, 0);
    send(8'hA5, w, bd);
    chk("b2b_second_waited", (w > 0), 1'b1);
    chk("b2b_second_on_boundary", bd, 1'b1);
    idle(30);
    idx = find_byte(base, 8'h33);
    chk8("b2b_first", rx_at(idx), 8'h33);
    chk8("b2b_second", rx_at(idx + 1), 8'hA5);

    // reserved payload
    e0 = err_pulses;
    align(2);
    send(BC, w, bd);
    idle(20);
    chk_int("err_pulse_count", err_pulses - e0, 1);

    // reset in the middle of 0xFF with another byte held
    align(4);
    send(8'hFF, w, bd);
    send(8'h77, w, bd);
    bus.valid_in = 1'b0;
    tick(2);
    chk_int("reset_at_bit3", e_cnt % 8, 3);
    reset = 1'b1;
    tick(1);
    chk("rst_data_out", bus.data_out, 1'b0);
    chk("rst_active_out", bus.active_out, 1'b0);
    chk("rst_ready_out", bus.ready_out, 1'b0);
    reset = 1'b0;
    base  = rx_q.size();
    tick(48);
    chk_int("restart_active_rise", active_rise, 25);
    for (int i = 0; i < 4; i++) chk8("restart_preamble", rx_at(base + i), BC);
    chk_int("discarded_byte_absent", find_byte(base, 8'h77), -1);

    // randomized traffic
    for (int n = 0; n < 200; n++) begin
      idle($urandom_range(0, 12));
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b1;
        tick($urandom_range(1, 3));
        reset = 1'b0;
      end
      b = 8'($urandom);
      if ($urandom_range(0, 19) == 0) b = BC;
      send(b, w, bd);
    end
    idle(20);

    hits = 0;
    for (int i = 0; i < 3; i++) hits += (find_byte(0, 8'hA5) >= 0) ? 1 : 0;
    chk_int("a5_seen", hits, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
